cpu_bus: RTL and testbench
==========================

# cpu_bus

Bus-cycle decoder sitting directly downstream of the Z80 core wrapper. It samples the core's active-low strobes on the core's positive clock enable, classifies each bus cycle once, and issues single-clock strobes with latched address and data to the memory map, video and I/O blocks. It also generates the core's active-low NMI from an asynchronous button request.

## Interface
Parameters:
- NMI_LEN, 16: NMI low time, counted in cep-qualified clocks (1..255).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- cep  in  1  core positive clock enable; all bus sampling is qualified by it.
- mreq, iorq, rd, wr, m1, rfsh  in  1 each  core strobes, active-low.
- a  in  16  core address.
- q  in  8  core write data.
- nmi_btn  in  1  NMI request, active-high, asynchronous to clock.
- mem_rd  out  1  one-clock pulse: memory read (includes opcode fetch).
- opfetch  out  1  one-clock pulse, coincident with mem_rd, for M1 fetches.
- mem_wr  out  1  one-clock pulse: memory write.
- io_rd  out  1  one-clock pulse: I/O read.
- io_wr  out  1  one-clock pulse: I/O write.
- inta  out  1  one-clock pulse: interrupt acknowledge (m1 and iorq low).
- refresh  out  1  one-clock pulse: refresh cycle.
- cyc_addr  out  16  address latched at classification.
- cyc_data  out  8  q latched at classification (writes only; held otherwise).
- busy  out  1  high while a classified cycle is in progress.
- nmi  out  1  active-low NMI to core.

## Operation
- Reset (reset low, asynchronous): state IDLE; all pulse outputs 0; cyc_addr 0000h; cyc_data 00h; busy 0; nmi 1; NMI counter 0; synchronizer flops 0.
- State machine, evaluated only on clocks with cep high; with cep low, state and latches hold and pulse outputs are 0.
- IDLE, priority order on the sampled strobes:
  - iorq low and m1 low -> inta; ACTIVE.
  - mreq low and rfsh low -> refresh; ACTIVE.
  - mreq low and rd low -> mem_rd (opfetch also if m1 low); ACTIVE.
  - mreq low and wr low -> mem_wr; latch q; ACTIVE.
  - iorq low and rd low -> io_rd; ACTIVE.
  - iorq low and wr low -> io_wr; latch q; ACTIVE.
  - mreq or iorq low with neither rd nor wr (write T1) -> remain IDLE, no pulse.
  - otherwise remain IDLE.
- Every classification latches a into cyc_addr.
- ACTIVE: no further pulses. Return to IDLE when mreq and iorq are both sampled high.
- busy = (state == ACTIVE).
- Exactly one pulse per bus cycle, regardless of strobe length or wait states.
- NMI path:
  - nmi_btn passes through a two-flop synchronizer, then a rising-edge detector.
  - An edge with the counter at 0 loads NMI_LEN and drives nmi low.
  - The counter decrements on cep clocks; nmi returns high when it reaches 0.
  - Edges arriving while the counter is non-zero are ignored (no retrigger, no queueing).

## Timing
- Pulse latency: a pulse is asserted in the clock after the cep-qualified edge that samples the qualifying strobes. It lasts exactly one clock. cyc_addr and cyc_data are valid in the same clock as the pulse and hold until the next classification.
- Memory write: mreq falls first, wr falls one half T-state later. mem_wr fires on the first cep sample that sees wr low, so q is stable when latched.
- Back-to-back cycles: IDLE must be re-entered, i.e. one cep sample with mreq and iorq both high, before the next classification. A refresh immediately following a fetch therefore yields separate opfetch and refresh pulses.
- Reset asserted mid-cycle: any pulse in flight is squashed; the machine starts in IDLE. A strobe pattern already low at reset release is classified on the first cep sample.
- nmi_btn-to-nmi latency: 2 clocks of synchronizer, plus 1 clock for edge detect and load. nmi stays low for NMI_LEN cep clocks.

## Test plan
- Opcode fetch: m1, mreq and rd low at a=1234h, held 3 cep samples, then refresh at a=0080h -> one mem_rd+opfetch with cyc_addr=1234h; then one refresh with cyc_addr=0080h; busy drops between them.
- Memory write: mreq low one sample before wr, a=4400h, q=A5h -> single mem_wr, no mem_rd, cyc_addr=4400h, cyc_data=A5h.
- I/O and interrupt acknowledge: iorq+wr at a=00FFh with q=3Ch -> io_wr, cyc_data=3Ch. iorq+rd at a=00FEh -> io_rd. iorq+m1 -> inta only, no io_rd.
- cep gating: a strobe held low over 10 clocks with cep high every 4th clock -> exactly one pulse, one clock after the first cep sample.
- NMI: NMI_LEN=16, nmi_btn pulse -> nmi low within 3 clocks, low for 16 cep clocks. A second nmi_btn edge while low -> no extension. An edge after nmi returns high -> a new 16-cep NMI.
- Reset mid-cycle: reset low during ACTIVE with nmi low -> all outputs at reset values immediately, nmi=1. After release with mreq and rd low -> one mem_rd.

Source files
------------

// File: rtl/cpu_bus.sv
// Z80 bus-cycle decoder: classifies each core bus cycle once on cep and emits
// single-clock strobes with latched address/data, plus a fixed-length NMI generator.
module cpu_bus #(
  parameter int unsigned NMI_LEN = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cep,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  input  logic        rfsh,
  input  logic [15:0] a,
  input  logic [7:0]  q,
  input  logic        nmi_btn,
  output logic        mem_rd,
  output logic        opfetch,
  output logic        mem_wr,
  output logic        io_rd,
  output logic        io_wr,
  output logic        inta,
  output logic        refresh,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_data,
  output logic        busy,
  output logic        nmi
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic       sync1, sync2, sync3;
  logic       nmi_edge;
  logic [7:0] nmi_cnt;

  assign busy     = (state == ACTIVE);
  assign nmi_edge = sync2 & ~sync3;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      opfetch  <= 1'b0;
      mem_wr   <= 1'b0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      inta     <= 1'b0;
      refresh  <= 1'b0;
      cyc_addr <= 16'h0000;
      cyc_data <= 8'h00;
    end else begin
      // Pulses default low every clock so each one lasts exactly one cycle.
      mem_rd  <= 1'b0;
      opfetch <= 1'b0;
      mem_wr  <= 1'b0;
      io_rd   <= 1'b0;
      io_wr   <= 1'b0;
      inta    <= 1'b0;
      refresh <= 1'b0;
      if (cep) begin
        unique case (state)
          IDLE: begin
            if (!iorq && !m1) begin
              inta     <= 1'b1;
              cyc_addr <= a;
              state    <= ACTIVE;
            end else if (!mreq && !rfsh) begin
              refresh  <= 1'b1;
              cyc_addr <= a;
              state    <= ACTIVE;
            end else if (!mreq && !rd) begin
              mem_rd   <= 1'b1;
              opfetch  <= ~m1;
              cyc_addr <= a;
              state    <= ACTIVE;
            end else if (!mreq && !wr) begin
              mem_wr   <= 1'b1;
              cyc_addr <= a;
              cyc_data <= q;
              state    <= ACTIVE;
            end else if (!iorq && !rd) begin
              io_rd    <= 1'b1;
              cyc_addr <= a;
              state    <= ACTIVE;
            end else if (!iorq && !wr) begin
              io_wr    <= 1'b1;
              cyc_addr <= a;
              cyc_data <= q;
              state    <= ACTIVE;
            end
          end
          ACTIVE: begin
            // One idle sample with both requests high re-arms classification.
            if (mreq && iorq) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NMI: two-flop synchronizer, rising-edge detect, non-retriggerable counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      nmi_cnt <= 8'd0;
      nmi     <= 1'b1;
    end else begin
      sync1 <= nmi_btn;
      sync2 <= sync1;
      sync3 <= sync2;
      if (nmi_edge && nmi_cnt == 8'd0) begin
        nmi_cnt <= 8'(NMI_LEN);
        nmi     <= 1'b0;
      end else if (cep && nmi_cnt != 8'd0) begin
        nmi_cnt <= nmi_cnt - 8'd1;
        if (nmi_cnt == 8'd1) nmi <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus.sv
// Directed self-checking bench for cpu_bus: bus classification, cep gating, NMI and reset.
module tb_cpu_bus;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cep = 1'b1;
  logic        mreq = 1'b1, iorq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1, rfsh = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  q = 8'h00;
  logic        nmi_btn = 1'b0;
  logic        mem_rd, opfetch, mem_wr, io_rd, io_wr, inta, refresh;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_data;
  logic        busy, nmi;

  int checks = 0;
  int errors = 0;
  int n_mem_rd = 0, n_opfetch = 0, n_mem_wr = 0, n_io_rd = 0, n_io_wr = 0;
  int n_inta = 0, n_refresh = 0;

  cpu_bus #(.NMI_LEN(16)) dut (
    .clock(clock), .reset(reset), .cep(cep),
    .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .rfsh(rfsh),
    .a(a), .q(q), .nmi_btn(nmi_btn),
    .mem_rd(mem_rd), .opfetch(opfetch), .mem_wr(mem_wr), .io_rd(io_rd),
    .io_wr(io_wr), .inta(inta), .refresh(refresh),
    .cyc_addr(cyc_addr), .cyc_data(cyc_data), .busy(busy), .nmi(nmi)
  );

  always #5 clock = ~clock;

  // Pulse tally sampled mid-cycle, used to prove "exactly one pulse per cycle".
  always @(negedge clock) begin
    if (mem_rd)  n_mem_rd++;
    if (opfetch) n_opfetch++;
    if (mem_wr)  n_mem_wr++;
    if (io_rd)   n_io_rd++;
    if (io_wr)   n_io_wr++;
    if (inta)    n_inta++;
    if (refresh) n_refresh++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input logic c);
    cep = c;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
  endtask

  task automatic measure_nmi_low(input string tag);
    int low = 1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      if (nmi == 1'b0) low++;
      else break;
    end
    check(tag, low, 16);
  endtask

  int b_rd, b_of, b_wr, b_iord, b_iowr, b_inta, b_rf;

  initial begin
    // Reset state
    repeat (3) tick(1'b1);
    check("rst_pulses", {mem_rd, opfetch, mem_wr, io_rd, io_wr, inta, refresh}, 0);
    check("rst_addr", cyc_addr, 16'h0000);
    check("rst_data", cyc_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_nmi", nmi, 1);
    reset = 1'b1;
    tick(1'b1);

    // Opcode fetch held 3 samples, then refresh
    b_rd = n_mem_rd; b_of = n_opfetch; b_rf = n_refresh;
    m1 = 1'b0; mreq = 1'b0; rd = 1'b0; a = 16'h1234;
    tick(1'b1);
    check("fetch_mem_rd", mem_rd, 1);
    check("fetch_opfetch", opfetch, 1);
    check("fetch_addr", cyc_addr, 16'h1234);
    check("fetch_busy", busy, 1);
    tick(1'b1);
    check("fetch_one_clock", mem_rd, 0);
    tick(1'b1);
    idle_bus();
    tick(1'b1);
    check("fetch_busy_drop", busy, 0);
    mreq = 1'b0; rfsh = 1'b0; a = 16'h0080;
    tick(1'b1);
    check("rfsh_pulse", refresh, 1);
    check("rfsh_no_rd", mem_rd, 0);
    check("rfsh_addr", cyc_addr, 16'h0080);
    tick(1'b1);
    idle_bus();
    tick(1'b1);
    check("fetch_rd_count", n_mem_rd - b_rd, 1);
    check("fetch_of_count", n_opfetch - b_of, 1);
    check("rfsh_count", n_refresh - b_rf, 1);

    // Memory write: mreq leads wr by one sample
    b_rd = n_mem_rd; b_wr = n_mem_wr;
    mreq = 1'b0; a = 16'h4400; q = 8'hA5;
    tick(1'b1);
    check("wr_t1_nopulse", mem_wr, 0);
    check("wr_t1_idle", busy, 0);
    wr = 1'b0;
    tick(1'b1);
    check("wr_pulse", mem_wr, 1);
    check("wr_addr", cyc_addr, 16'h4400);
    check("wr_data", cyc_data, 8'hA5);
    tick(1'b1);
    idle_bus();
    tick(1'b1);
    check("wr_count", n_mem_wr - b_wr, 1);
    check("wr_no_rd", n_mem_rd - b_rd, 0);

    // I/O write, I/O read, interrupt acknowledge
    b_iord = n_io_rd; b_iowr = n_io_wr; b_inta = n_inta;
    iorq = 1'b0; wr = 1'b0; a = 16'h00FF; q = 8'h3C;
    tick(1'b1);
    check("iowr_pulse", io_wr, 1);
    check("iowr_data", cyc_data, 8'h3C);
    idle_bus();
    tick(1'b1);
    iorq = 1'b0; rd = 1'b0; a = 16'h00FE; q = 8'h77;
    tick(1'b1);
    check("iord_pulse", io_rd, 1);
    check("iord_addr", cyc_addr, 16'h00FE);
    check("iord_data_held", cyc_data, 8'h3C);
    idle_bus();
    tick(1'b1);
    iorq = 1'b0; m1 = 1'b0; a = 16'h0038;
    tick(1'b1);
    check("inta_pulse", inta, 1);
    check("inta_no_iord", io_rd, 0);
    idle_bus();
    tick(1'b1);
    check("iord_count", n_io_rd - b_iord, 1);
    check("iowr_count", n_io_wr - b_iowr, 1);
    check("inta_count", n_inta - b_inta, 1);

    // cep gating: strobe held 10 clocks, cep every 4th clock
    b_rd = n_mem_rd;
    mreq = 1'b0; rd = 1'b0; a = 16'h2000;
    for (int i = 0; i < 10; i++) begin
      tick((i % 4) == 3);
      if (i == 2) check("cep_before", mem_rd, 0);
      if (i == 3) check("cep_first", mem_rd, 1);
      if (i == 4) check("cep_one_clock", mem_rd, 0);
    end
    idle_bus();
    tick(1'b1);
    tick(1'b1);
    check("cep_count", n_mem_rd - b_rd, 1);

    // NMI: latency, length, no retrigger, new NMI afterwards
    nmi_btn = 1'b1;
    tick(1'b1);
    tick(1'b1);
    check("nmi_latency_2", nmi, 1);
    tick(1'b1);
    check("nmi_latency_3", nmi, 0);
    nmi_btn = 1'b0;
    repeat (3) tick(1'b1);
    nmi_btn = 1'b1;
    repeat (3) tick(1'b1);
    nmi_btn = 1'b0;
    check("nmi_still_low", nmi, 0);
    begin
      int low = 7;
      for (int i = 0; i < 40; i++) begin
        tick(1'b1);
        if (nmi == 1'b0) low++;
        else break;
      end
      check("nmi_no_extend", low, 16);
    end
    repeat (4) tick(1'b1);
    check("nmi_stays_high", nmi, 1);
    nmi_btn = 1'b1;
    repeat (3) tick(1'b1);
    check("nmi2_low", nmi, 0);
    measure_nmi_low("nmi2_len");
    nmi_btn = 1'b0;
    repeat (3) tick(1'b1);

    // Reset mid-cycle with nmi low
    b_rd = n_mem_rd;
    nmi_btn = 1'b1;
    mreq = 1'b0; rd = 1'b0; a = 16'h5555;
    tick(1'b1);
    check("pre_rst_rd", mem_rd, 1);
    tick(1'b1);
    tick(1'b1);
    check("pre_rst_nmi", nmi, 0);
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    nmi_btn = 1'b0;
    #1;
    check("mid_rst_pulses", {mem_rd, opfetch, mem_wr, io_rd, io_wr, inta, refresh}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_nmi", nmi, 1);
    check("mid_rst_addr", cyc_addr, 16'h0000);
    a = 16'h6666;
    tick(1'b1);
    #2;
    reset = 1'b1;
    tick(1'b1);
    check("post_rst_rd", mem_rd, 1);
    check("post_rst_addr", cyc_addr, 16'h6666);
    tick(1'b1);
    idle_bus();
    tick(1'b1);
    check("post_rst_count", n_mem_rd - b_rd, 2);
    check("post_rst_nmi", nmi, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
